// File: rtl/alu_defs.sv
// alu_defs: shared EX-stage definitions.
//   - ALU control codes, including ALU_MULT which selects the multi-cycle
//     multiply handled by mult_sequencer.
//   - 2-bit multiply-sequencer state encoding.
package alu_defs;

   // ALU control codes
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_MULT = 5'b00011;
   localparam logic [4:0] ALU_OR   = 5'b00100;
   localparam logic [4:0] ALU_XOR  = 5'b00101;
   localparam logic [4:0] ALU_NOR  = 5'b00110;
   localparam logic [4:0] ALU_SLT  = 5'b00111;
   localparam logic [4:0] ALU_SLL  = 5'b01000;
   localparam logic [4:0] ALU_SRL  = 5'b01001;
   localparam logic [4:0] ALU_SRA  = 5'b01010;
   localparam logic [4:0] ALU_LUI  = 5'b01011;
   localparam logic [4:0] ALU_BEQ  = 5'b01100;
   localparam logic [4:0] ALU_BNE  = 5'b01101;

   // Multiply sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add engine for the signed multiply.
//   Operands are converted to magnitudes on load; the product sign is
//   reapplied when the result is written to hi/lo.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture |opa|, |opb|, sign; clear accumulator and count
//   step         one shift-add iteration
//   finish       write the signed product of the current iteration to hi/lo
//   opa, opb     signed operands
//   last         this iteration is the final one
//   hi, lo       registered product halves
// Optional: MULT_EARLY_EXIT_EN also ends the run once the multiplier
//   register has shifted down to zero.
module mult_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             finish,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             last,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand, acc, sum, prod;
   logic [WIDTH-1:0]   mplr, absa, absb;
   logic [CW-1:0]      cnt;
   logic               sign;

   // 0x80..0 negates to itself, which is the correct unsigned magnitude
   assign absa = opa[WIDTH-1] ? -opa : opa;
   assign absb = opb[WIDTH-1] ? -opb : opb;

   // Accumulator value after this cycle's iteration; a zero multiplier
   // contributes no add, so an early exit can reuse the same result path.
   assign sum  = acc + (mplr[0] ? mcand : '0);
   assign prod = sign ? -sum : sum;

`ifdef MULT_EARLY_EXIT_EN
   assign last = (cnt == CW'(WIDTH-1)) || (mplr == '0);
`else
   assign last = (cnt == CW'(WIDTH-1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand <= '0;
         acc   <= '0;
         mplr  <= '0;
         cnt   <= '0;
         sign  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         if (load) begin
            mcand <= {{WIDTH{1'b0}}, absa};
            mplr  <= absb;
            acc   <= '0;
            cnt   <= '0;
            sign  <= opa[WIDTH-1] ^ opb[WIDTH-1];
         end else if (step) begin
            acc   <= sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
         end
         if (finish)
            {hi, lo} <= prod;
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: EX-stage multi-cycle signed multiply controller.
//   Accepts a multiply from EX, holds Stall while mult_datapath iterates,
//   then pulses Done for one cycle with the product on Hi/Lo.
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   Start        EX holds a valid instruction
//   ALUControl   decoded ALU control of that instruction
//   Flush        squash the EX instruction
//   OpA, OpB     signed operands
//   Stall        freeze IF/ID/EX (combinational)
//   Done         one-cycle pulse, Hi/Lo valid
//   Hi, Lo       product halves, held until the next completed multiply
// Optional: MULT_EARLY_EXIT_EN (in mult_datapath) shortens RUN once the
//   remaining multiplier bits are zero.
module mult_sequencer
   import alu_defs::*;
#(
   parameter int         WIDTH     = 32,
   parameter logic [4:0] MULT_CODE = ALU_MULT
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [4:0]       ALUControl,
   input  logic             Flush,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Stall,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   mult_state_t state, nstate;
   logic        accept, load, step, finish, last, done_q;

   assign accept = Start && (ALUControl == MULT_CODE) && !Flush;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= nstate;
         done_q <= finish;
      end
   end

   // Stall is combinational so the accepting cycle is already frozen.
   // DONE drops Stall so the multiply retires while Done is high.
   always_comb begin
      nstate = state;
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      Stall  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               Stall  = 1'b1;
               load   = 1'b1;
               nstate = RUN;
            end
         end
         RUN: begin
            Stall = 1'b1;
            if (Flush) begin
               nstate = IDLE;
            end else begin
               step = 1'b1;
               if (last) begin
                  finish = 1'b1;
                  nstate = DONE;
               end
            end
         end
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   assign Done = done_q;

   mult_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk    (Clk),
      .rst    (Rst),
      .load   (load),
      .step   (step),
      .finish (finish),
      .opa    (OpA),
      .opb    (OpB),
      .last   (last),
      .hi     (Hi),
      .lo     (Lo)
   );

endmodule
